obuf_seq_ctrl: RTL and testbench

- Sequencer for the strided output-feature-map buffer (CO channels × OUT_DIM × OUT_DIM words).
- Accepts a raster stream of PE-array results and issues buffer writes; then drains the buffer in the same order as a valid-tagged stream.
- Sits between the PE array accumulator output and the next-layer input loader.
- Owns all buffer addr_x/addr_y/addr_c/we/re generation.

---
 rtl/cnn_buf_pkg.sv | 39 +++
 rtl/obuf_seq_ctrl_if.sv | 42 ++++
 rtl/obuf_xyc_counter.sv | 73 +++++++
 rtl/obuf_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_obuf_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : cnn_buf_pkg                                                      |
// | Brief   : Geometry helpers and sequencer state encoding for the output     |
// |           feature-map buffer controller.                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package cnn_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int calc_out_dim(input int ifm, input int k, input int pad, input int stride);
    return (ifm - k + 2 * pad) / stride + 1;
  endfunction

  function automatic int calc_addr(input int ifm, input int k, input int pad);
    return $clog2(ifm - k + 2 * pad + 1);
  endfunction

  function automatic int calc_addr_c(input int co);
    return $clog2(co);
  endfunction

  function automatic int calc_total(input int co, input int out_dim);
    return co * out_dim * out_dim;
  endfunction

  // Counter width able to hold 0..n-1 (never narrower than one bit)
  function automatic int calc_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obuf_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : obuf_seq_ctrl_if                                               |
// | Brief     : Result stream, drain stream and buffer port bundle of the      |
// |             output-buffer sequencer. master = environment, slave = ctrl.   |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface obuf_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 6,
  parameter int CAW        = 5
);
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  rd_en;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         buf_addr_x;
  logic [AW-1:0]         buf_addr_y;
  logic [CAW-1:0]        buf_addr_c;
  logic [DATA_WIDTH-1:0] buf_d_in;
  logic                  buf_we;
  logic                  buf_re;
  logic [DATA_WIDTH-1:0] buf_d_out;

  modport master (
    output start, in_valid, in_data, rd_en, buf_d_out,
    input  in_ready, out_valid, out_data, busy, done,
           buf_addr_x, buf_addr_y, buf_addr_c, buf_d_in, buf_we, buf_re
  );

  modport slave (
    input  start, in_valid, in_data, rd_en, buf_d_out,
    output in_ready, out_valid, out_data, busy, done,
           buf_addr_x, buf_addr_y, buf_addr_c, buf_d_in, buf_we, buf_re
  );
endinterface
`default_nettype wire

// File: rtl/obuf_xyc_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : obuf_xyc_counter                                                  |
// | Brief  : Nested x/y/c raster counter (x fastest, then y, then c) with      |
// |          increment, clear and a last-position flag.                        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module obuf_xyc_counter #(
  parameter int OUT_DIM = 5,
  parameter int CO      = 8,
  parameter int XW      = 3,
  parameter int CW      = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          inc,
  input  wire logic          clr,
  output logic [XW-1:0]      x,
  output logic [XW-1:0]      y,
  output logic [CW-1:0]      c,
  output logic               last
);
  logic [XW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] c_q, c_d;
  logic          x_wrap, y_wrap, c_wrap;

  assign x_wrap = (x_q == XW'(OUT_DIM - 1));
  assign y_wrap = (y_q == XW'(OUT_DIM - 1));
  assign c_wrap = (c_q == CW'(CO - 1));
  assign last   = x_wrap & y_wrap & c_wrap;

  // Next position: clear wins over increment; carries ripple x -> y -> c
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    c_d = c_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
      c_d = '0;
    end else if (inc) begin
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) begin
          y_d = '0;
          c_d = c_wrap ? '0 : c_q + 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      c_q <= c_d;
    end
  end

  assign x = x_q;
  assign y = y_q;
  assign c = c_q;
endmodule
`default_nettype wire

// File: rtl/obuf_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : obuf_seq_ctrl                                                     |
// | Brief  : Output feature-map buffer sequencer. Writes a raster stream of    |
// |          PE results into the strided buffer, then drains it in the same    |
// |          order as a valid-tagged stream gated by rd_en.                    |
// | Option : OBUF_STALL_CNT_EN adds stall_cnt[31:0] (WRITE idle-input cycles   |
// |          plus READ cycles with rd_en low).                                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module obuf_seq_ctrl
  import cnn_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IFM_SIZE    = 9,
  parameter int KERNEL_SIZE = 4,
  parameter int STRIDE      = 2,
  parameter int PAD         = 2,
  parameter int CO          = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  obuf_seq_ctrl_if.slave  bus
`ifdef OBUF_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);
  localparam int OUT_DIM = calc_out_dim(IFM_SIZE, KERNEL_SIZE, PAD, STRIDE);
  localparam int ADDR    = calc_addr(IFM_SIZE, KERNEL_SIZE, PAD);
  localparam int ADDR_C  = calc_addr_c(CO);
  localparam int AW      = ADDR + 2;
  localparam int CAW     = ADDR_C + 2;
  localparam int XW      = calc_cnt_w(OUT_DIM);
  localparam int CW      = calc_cnt_w(CO);

  state_e                state_q, state_d;
  logic                  drain_wait_q, drain_wait_d;
  logic [XW-1:0]         cnt_x, cnt_y;
  logic [CW-1:0]         cnt_c;
  logic                  cnt_last, cnt_inc, cnt_clr;
  logic                  wr_beat, rd_issue;

  logic                  buf_we_q, buf_we_d;
  logic                  buf_re_q, buf_re_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;
  logic [AW-1:0]         addr_x_q, addr_x_d;
  logic [AW-1:0]         addr_y_q, addr_y_d;
  logic [CAW-1:0]        addr_c_q, addr_c_d;
  logic [DATA_WIDTH-1:0] d_in_q, d_in_d;

  assign wr_beat  = (state_q == WRITE) && bus.in_valid;
  assign rd_issue = (state_q == READ) && bus.rd_en;
  assign cnt_inc  = wr_beat || rd_issue;
  // Last position of either phase returns the counter to the origin
  assign cnt_clr  = cnt_inc && cnt_last;

  obuf_xyc_counter #(
    .OUT_DIM (OUT_DIM),
    .CO      (CO),
    .XW      (XW),
    .CW      (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .x    (cnt_x),
    .y    (cnt_y),
    .c    (cnt_c),
    .last (cnt_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      drain_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_wait_q <= drain_wait_d;
    end
  end

  // Next-state: DRAIN spends one cycle letting the final out_valid emerge
  always_comb begin
    state_d      = state_q;
    drain_wait_d = (state_q == DRAIN) && !drain_wait_q;
    case (state_q)
      IDLE:    if (bus.start)            state_d = WRITE;
      WRITE:   if (wr_beat && cnt_last)  state_d = READ;
      READ:    if (rd_issue && cnt_last) state_d = DRAIN;
      DRAIN:   if (drain_wait_q)         state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Output next values: write and read use different strided address maps
  always_comb begin
    buf_we_d    = wr_beat;
    buf_re_d    = rd_issue;
    out_valid_d = buf_re_q;
    done_d      = (state_q == DRAIN) && drain_wait_q;
    d_in_d      = wr_beat ? bus.in_data : d_in_q;
    addr_x_d    = addr_x_q;
    addr_y_d    = addr_y_q;
    addr_c_d    = addr_c_q;
    if (wr_beat) begin
      addr_x_d = AW'(cnt_x) * AW'(STRIDE);
      addr_y_d = AW'(cnt_y) * AW'(STRIDE) + AW'(1);
      addr_c_d = CAW'(cnt_c);
    end else if (rd_issue) begin
      addr_x_d = AW'(cnt_x) * AW'(STRIDE) + AW'(KERNEL_SIZE - 1);
      addr_y_d = AW'(cnt_y) * AW'(STRIDE);
      addr_c_d = CAW'(cnt_c);
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_we_q    <= 1'b0;
      buf_re_q    <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      addr_x_q    <= '0;
      addr_y_q    <= '0;
      addr_c_q    <= '0;
      d_in_q      <= '0;
    end else begin
      buf_we_q    <= buf_we_d;
      buf_re_q    <= buf_re_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      addr_x_q    <= addr_x_d;
      addr_y_q    <= addr_y_d;
      addr_c_q    <= addr_c_d;
      d_in_q      <= d_in_d;
    end
  end

  assign bus.in_ready   = (state_q == WRITE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.buf_we     = buf_we_q;
  assign bus.buf_re     = buf_re_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = bus.buf_d_out;
  assign bus.buf_addr_x = addr_x_q;
  assign bus.buf_addr_y = addr_y_q;
  assign bus.buf_addr_c = addr_c_q;
  assign bus.buf_d_in   = d_in_q;

`ifdef OBUF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall accounting: idle input in WRITE, withheld rd_en in READ
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == IDLE) && bus.start) begin
      stall_cnt_d = '0;
    end else if (((state_q == WRITE) && !bus.in_valid) ||
                 ((state_q == READ) && !bus.rd_en)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_obuf_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_obuf_seq_ctrl                                                  |
// | Brief  : Self-checking bench for obuf_seq_ctrl with a buffer RAM model,    |
// |          raster reference model and address vector tables.                |
// | Option : OBUF_STALL_CNT_EN also checks stall_cnt.                          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_obuf_seq_ctrl;
  localparam int DW    = 16;
  localparam int IFM   = 9;
  localparam int K     = 4;
  localparam int S     = 2;
  localparam int PAD   = 2;
  localparam int CO    = 8;
  localparam int OD    = (IFM - K + 2 * PAD) / S + 1;
  localparam int TOTAL = CO * OD * OD;
  localparam int AW    = $clog2(IFM - K + 2 * PAD + 1) + 2;
  localparam int CAW   = $clog2(CO) + 2;

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          ax;
    int          ay;
    int          ac;
  } vec_t;

  typedef struct {
    int ax;
    int ay;
    int ac;
    int d;
  } rec_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  obuf_seq_ctrl_if #(.DATA_WIDTH(DW), .AW(AW), .CAW(CAW)) bus ();
`ifdef OBUF_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  obuf_seq_ctrl #(
    .DATA_WIDTH (DW),
    .IFM_SIZE   (IFM),
    .KERNEL_SIZE(K),
    .STRIDE     (S),
    .PAD        (PAD),
    .CO         (CO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef OBUF_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int akey(input int ax, input int ay, input int ac);
    return (ac << 12) | (ay << 6) | ax;
  endfunction

  function automatic logic [DW-1:0] pattern(input int key);
    return DW'(key * 13 + 32'h0F00);
  endfunction

  // Buffer RAM model: unwritten locations read back a fixed address pattern
  logic [DW-1:0] wr_mem [int];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.buf_d_out <= '0;
    end else begin
      int wk, rk;
      wk = akey(int'(bus.buf_addr_x), int'(bus.buf_addr_y), int'(bus.buf_addr_c));
      rk = wk;
      if (bus.buf_re) bus.buf_d_out <= wr_mem.exists(rk) ? wr_mem[rk] : pattern(rk);
      if (bus.buf_we) wr_mem[wk] = bus.buf_d_in;
    end
  end

  // Monitor: logs buffer traffic and checks out_valid trails buf_re by one cycle
  rec_t wlog[$];
  rec_t rlog[$];
  int   olog[$];
  int   done_cnt;
  logic prev_re;
  always @(negedge clk) begin
    if (rst) begin
      prev_re = 1'b0;
    end else begin
      chk("out_valid_lag", bus.out_valid, prev_re);
      prev_re = bus.buf_re;
      if (bus.buf_we)
        wlog.push_back('{int'(bus.buf_addr_x), int'(bus.buf_addr_y), int'(bus.buf_addr_c), int'(bus.buf_d_in)});
      if (bus.buf_re)
        rlog.push_back('{int'(bus.buf_addr_x), int'(bus.buf_addr_y), int'(bus.buf_addr_c), 0});
      if (bus.out_valid) olog.push_back(int'(bus.out_data));
      if (bus.done) done_cnt++;
    end
  end

  vec_t        wtbl[5];
  vec_t        rtbl[5];
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] tbl_data(input int k);
    for (int i = 0; i < 5; i++) if (wtbl[i].idx == k) return wtbl[i].data;
    return DW'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_buf_we"}, bus.buf_we, 0);
    chk({tag, "_buf_re"}, bus.buf_re, 0);
    chk({tag, "_addr_x"}, bus.buf_addr_x, 0);
    chk({tag, "_addr_y"}, bus.buf_addr_y, 0);
    chk({tag, "_addr_c"}, bus.buf_addr_c, 0);
    chk({tag, "_d_in"}, bus.buf_d_in, 0);
  endtask

  // One layer: write TOTAL beats with gaps, then drain; abort_at>=0 resets mid-READ
  task automatic run_layer(input bit use_tbl, input int gap_pct, input int rd_mode, input int abort_at);
    int            acc, iss, cyc, stalls, guard;
    logic          rd;
    logic [DW-1:0] bd[$];
    wlog.delete(); rlog.delete(); olog.delete();
    done_cnt = 0;
    stalls   = 0;

    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hDEAD; bus.rd_en = 1'b0;
    tick();
    chk("start_beat_ignored", bus.buf_we, 0);
    chk("in_ready_write", bus.in_ready, 1);
    chk("busy_write", bus.busy, 1);

    acc = 0;
    while (acc < TOTAL) begin
      bus.start    = 1'($urandom_range(1));
      bus.rd_en    = 1'($urandom_range(1));
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_data  = use_tbl ? tbl_data(acc) : DW'($urandom);
      tick();
      chk("we_follows_beat", bus.buf_we, bus.in_valid);
      chk("no_re_in_write", bus.buf_re, 0);
      if (bus.in_valid) begin
        bd.push_back(bus.in_data);
        acc++;
      end else begin
        stalls++;
      end
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.rd_en = 1'b0;
    chk("in_ready_after_last", bus.in_ready, 0);
    chk("busy_in_read", bus.busy, 1);

    iss = 0;
    cyc = 0;
    while (iss < TOTAL && !(abort_at >= 0 && iss >= abort_at)) begin
      case (rd_mode)
        0:       rd = 1'b1;
        1:       rd = (cyc % 2 == 0);
        default: rd = 1'($urandom_range(1));
      endcase
      bus.rd_en = rd;
      tick();
      chk("re_follows_rd_en", bus.buf_re, rd);
      if (rd) iss++;
      else    stalls++;
      cyc++;
    end
    bus.rd_en = 1'b0;

    chk("we_count", wlog.size(), TOTAL);
    for (int k = 0; k < TOTAL && k < wlog.size(); k++) begin
      int x, y, c;
      x = k % OD; y = (k / OD) % OD; c = k / (OD * OD);
      chk("wr_addr_x", wlog[k].ax, x * S);
      chk("wr_addr_y", wlog[k].ay, y * S + 1);
      chk("wr_addr_c", wlog[k].ac, c);
      chk("wr_data", wlog[k].d, bd[k]);
      ref_mem[akey(x * S, y * S + 1, c)] = bd[k];
    end

    if (abort_at >= 0) begin
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      tick();
      check_all_zero("rst_next");
      rst = 1'b0;
      tick();
      check_all_zero("after_rst");
      return;
    end

    guard = 0;
    while (done_cnt == 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("done_seen", (done_cnt != 0), 1);
    repeat (3) tick();
    chk("done_once", done_cnt, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_in_ready", bus.in_ready, 0);
`ifdef OBUF_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif

    chk("re_count", rlog.size(), TOTAL);
    for (int k = 0; k < TOTAL && k < rlog.size(); k++) begin
      int x, y, c;
      x = k % OD; y = (k / OD) % OD; c = k / (OD * OD);
      chk("rd_addr_x", rlog[k].ax, x * S + K - 1);
      chk("rd_addr_y", rlog[k].ay, y * S);
      chk("rd_addr_c", rlog[k].ac, c);
    end
    chk("ov_count", olog.size(), TOTAL);
    for (int k = 0; k < TOTAL && k < olog.size(); k++) begin
      int x, y, c, key;
      x = k % OD; y = (k / OD) % OD; c = k / (OD * OD);
      key = akey(x * S + K - 1, y * S, c);
      chk("out_data", olog[k], ref_mem.exists(key) ? ref_mem[key] : pattern(key));
    end
  endtask

  initial begin
    wtbl[0] = '{0,   16'h1234, 0, 1, 0};
    wtbl[1] = '{6,   16'h0607, 2, 3, 0};
    wtbl[2] = '{24,  16'h2424, 8, 9, 0};
    wtbl[3] = '{25,  16'hC001, 0, 1, 1};
    wtbl[4] = '{199, 16'hBEEF, 8, 9, 7};
    rtbl[0] = '{0,   16'h0000, 3,  0, 0};
    rtbl[1] = '{1,   16'h0000, 5,  0, 0};
    rtbl[2] = '{5,   16'h0000, 3,  2, 0};
    rtbl[3] = '{25,  16'h0000, 3,  0, 1};
    rtbl[4] = '{199, 16'h0000, 11, 8, 7};

    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.rd_en = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Layer 1: back-to-back beats with tabled data, continuous rd_en
    run_layer(1'b1, 0, 0, -1);
    for (int i = 0; i < 5; i++) begin
      if (wtbl[i].idx < wlog.size()) begin
        chk("tbl_wr_x", wlog[wtbl[i].idx].ax, wtbl[i].ax);
        chk("tbl_wr_y", wlog[wtbl[i].idx].ay, wtbl[i].ay);
        chk("tbl_wr_c", wlog[wtbl[i].idx].ac, wtbl[i].ac);
        chk("tbl_wr_d", wlog[wtbl[i].idx].d, wtbl[i].data);
      end else begin
        chk("tbl_wr_present", wlog.size(), wtbl[i].idx + 1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (rtbl[i].idx < rlog.size()) begin
        chk("tbl_rd_x", rlog[rtbl[i].idx].ax, rtbl[i].ax);
        chk("tbl_rd_y", rlog[rtbl[i].idx].ay, rtbl[i].ay);
        chk("tbl_rd_c", rlog[rtbl[i].idx].ac, rtbl[i].ac);
      end else begin
        chk("tbl_rd_present", rlog.size(), rtbl[i].idx + 1);
      end
    end

    // Layer 2: gappy writes, rd_en toggling 1/0
    run_layer(1'b0, 30, 1, -1);
    // Layer 3: aborted by reset in the middle of READ
    run_layer(1'b0, 20, 0, 40);
    // Layer 4: clean layer after the abort, random rd_en
    run_layer(1'b0, 40, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
